// File: rtl/instr_encoder.sv
// RISC-V instruction word encoder with a one-entry registered output stage.
// Each accepted request is packed by opcode, tagged with a running address and checked for field overflow.
module instr_encoder #(
  parameter int               nbits     = 32,
  parameter logic [nbits-1:0] BASE_ADDR = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [nbits-1:0] START_ADDR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNCT3,
  input  logic [6:0]       FUNCT7,
  input  logic [4:0]       RS1,
  input  logic [4:0]       RS2,
  input  logic [4:0]       RD,
  input  logic [nbits-1:0] IMM,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [nbits-1:0] IR_OUT,
  output logic [nbits-1:0] ADDR_OUT,
  output logic [1:0]       ERR_OUT,
  output logic [15:0]      ERR_CNT
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

  logic [31:0]      imm;
  logic [31:0]      enc_word;
  logic [1:0]       enc_err;
  logic             accept;
  logic [nbits-1:0] naddr;
  logic [nbits-1:0] start_base;

  logic i_range_bad;
  logic b_range_bad;
  logic j_range_bad;
  logic u_low_bad;

  assign imm        = IMM[31:0];
  assign start_base = START_ADDR & ~nbits'(3);

  // Immediates must be sign-extensions of the field actually encoded.
  assign i_range_bad = !((&imm[31:11]) || !(|imm[31:11]));
  assign b_range_bad = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
  assign j_range_bad = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
  assign u_low_bad   = |imm[11:0];

  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 2'b10;
    case (OPCODE)
      OPC_LOAD, OPC_OPIMM: begin
        enc_word = {imm[11:0], RS1, FUNCT3, RD, OPCODE};
        enc_err  = {1'b0, i_range_bad};
      end
      OPC_STORE: begin
        enc_word = {imm[11:5], RS2, RS1, FUNCT3, imm[4:0], OPCODE};
        enc_err  = {1'b0, i_range_bad};
      end
      OPC_OP: begin
        enc_word = {FUNCT7, RS2, RS1, FUNCT3, RD, OPCODE};
        enc_err  = 2'b00;
      end
      OPC_LUI, OPC_AUIPC: begin
        enc_word = {imm[31:12], RD, OPCODE};
        enc_err  = {1'b0, u_low_bad};
      end
      OPC_BRANCH: begin
        enc_word = {imm[12], imm[10:5], RS2, RS1, FUNCT3, imm[4:1], imm[11], OPCODE};
        enc_err  = {1'b0, b_range_bad};
      end
      OPC_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], RD, OPCODE};
        enc_err  = {1'b0, j_range_bad};
      end
      default: begin
        enc_word = NOP_WORD;
        enc_err  = 2'b10;
      end
    endcase
  end

  // START blocks acceptance so an address reload never races a request.
  assign IN_READY = !START && (!OUT_VALID || OUT_READY);
  assign accept   = IN_VALID && IN_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
      IR_OUT    <= '0;
      ADDR_OUT  <= BASE_ADDR;
      ERR_OUT   <= 2'b00;
    end else if (accept) begin
      OUT_VALID <= 1'b1;
      IR_OUT    <= nbits'(enc_word);
      ADDR_OUT  <= naddr;
      ERR_OUT   <= enc_err;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      naddr <= BASE_ADDR;
    end else if (START) begin
      naddr <= start_base;
    end else if (accept) begin
      naddr <= naddr + nbits'(4);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ERR_CNT <= 16'd0;
    end else if (accept && (enc_err != 2'b00) && (ERR_CNT != 16'hFFFF)) begin
      ERR_CNT <= ERR_CNT + 16'd1;
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The parameter list SHALL be one per line: nbits, 32, data and address width; BASE_ADDR, 32'h0, first address after reset.
REQ-002 The ports SHALL be one per line: name, direction, width, meaning. Clock and reset come first:
CLK  in  1  single clock; all state on rising edge
RST  in  1  asynchronous reset, active-high
START  in  1  load address counter from START_ADDR
START_ADDR  in  nbits  new next-address; bits[1:0] forced to 00
IN_VALID  in  1  encode request valid
IN_READY  out  1  request accepted when IN_VALID&&IN_READY
OPCODE  in  7  RISC-V opcode
FUNCT3  in  3  funct3 field
FUNCT7  in  7  funct7 field (R-type only)
RS1, RS2, RD  in  5 each  register indices
IMM  in  nbits  signed byte-offset/immediate, unencoded
OUT_VALID  out  1  encoded word valid
OUT_READY  in  1  consumer accepts when OUT_VALID&&OUT_READY
IR_OUT  out  nbits  encoded instruction word
ADDR_OUT  out  nbits  address assigned to IR_OUT
ERR_OUT  out  2  bit0 range/alignment error, bit1 illegal opcode
ERR_CNT  out  16  count of accepted words with ERR_OUT!=0

Function
REQ-003 Fields SHALL be placed per opcode, with OPCODE in IR_OUT[6:0] in every case:
- LOAD 0000011, OP-IMM 0010011: IMM[11:0], RS1, FUNCT3, RD.
- STORE 0100011: IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0].
- OP 0110011: FUNCT7, RS2, RS1, FUNCT3, RD.
- LUI 0110111, AUIPC 0010111: IMM[31:12], RD.
- BRANCH 1100011: IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11].
- JAL 1101111: IMM[20], IMM[10:1], IMM[11], IMM[19:12], RD.
REQ-004 ERR bit0 SHALL be set under these conditions, while the word is still encoded from the truncated fields:
- I/S: IMM[31:11] not all equal.
- BRANCH: IMM[31:12] not all equal, or IMM[0]=1.
- JAL: IMM[31:20] not all equal, or IMM[0]=1.
- LUI/AUIPC: IMM[11:0]!=0.
- OP: never.
REQ-005 On any other OPCODE, the block SHALL set ERR bit1, clear bit0, and output 32'h00000013 (NOP).
REQ-006 IN_READY SHALL equal !START && (!OUT_VALID || OUT_READY), which gives one-entry output register throughput of 1 word/cycle.
REQ-007 Latency SHALL be 1 cycle: a request accepted at edge N appears on IR_OUT/ADDR_OUT/ERR_OUT with OUT_VALID=1 after edge N.
REQ-008 While OUT_VALID=1 and OUT_READY=0, IR_OUT, ADDR_OUT and ERR_OUT SHALL hold stable.
REQ-009 If the output is consumed with no new accept, OUT_VALID SHALL clear next cycle; a simultaneous consume and accept SHALL replace the word with no bubble.
REQ-010 The internal next-address NADDR SHALL work as follows:
- On accept, ADDR_OUT<=NADDR and NADDR<=NADDR+4, modulo 2^nbits; 32'hFFFFFFFC wraps to 0.
- On START, NADDR<=START_ADDR & ~3.
- START has priority over IN_VALID (no accept that cycle).
- A pending output word is neither dropped nor modified by START.
REQ-011 ERR_CNT SHALL increment on each accept whose computed error is non-zero, saturating at 16'hFFFF.
REQ-012 Outputs SHALL be registered; no combinational path SHALL run from OPCODE/IMM to any output except IN_READY (which depends on START/OUT_READY only).

Reset
REQ-013 While RST=1, the block SHALL asynchronously set: OUT_VALID=0, IR_OUT=0, ERR_OUT=0, ERR_CNT=0, ADDR_OUT=BASE_ADDR, NADDR=BASE_ADDR.
REQ-014 A reset asserted mid-transfer SHALL discard the pending word; IN_READY SHALL be 1 in the first cycle after release (START=0).

Verification
REQ-015 Encode check: after reset, OP-IMM RD=1 RS1=2 FUNCT3=0 IMM=32'hFFFFFFFF -> IR_OUT=32'hFFF10093, ADDR_OUT=0, ERR_OUT=00; then STORE RS1=2 RS2=5 FUNCT3=010 IMM=8 -> 32'h00512423, ADDR_OUT=4.
REQ-016 Branch/jump check: BRANCH RS1=RS2=0 FUNCT3=0 IMM=-4 -> 32'hFE000EE3; JAL RD=1 IMM=2048 -> 32'h001000EF; JAL IMM=3 -> ERR_OUT=01, ERR_CNT increments.
REQ-017 Error check: OP-IMM RD=1 RS1=2 IMM=2048 -> IR_OUT=32'h80010093, ERR_OUT=01; OPCODE=7'b1111111 -> IR_OUT=32'h00000013, ERR_OUT=10; ERR_CNT=2.
REQ-018 Backpressure check: OUT_READY=0 for 3 cycles with IN_VALID=1 -> IN_READY=0, first word stable; on release, words emerge in order at addresses 0,4 with no loss or duplication.
REQ-019 Address control check: START with START_ADDR=32'h103 -> next accepted word has ADDR_OUT=32'h100; START_ADDR=32'hFFFFFFFC followed by two accepts -> ADDR_OUT=FFFFFFFC then 0.
REQ-020 Reset check: RST pulsed with OUT_VALID=1 and ERR_CNT=5 -> all outputs at REQ-013 values immediately, without waiting for a CLK edge.
